rom_bit_sequencer: RTL
======================

// Module: rom_bit_sequencer
// PURPOSE
//  Reads a 1-bit-wide block-ROM pattern one address at a time. Each step is paced by an
//  external one-cycle tick (the one-second enable). The read latency of the ROM is absorbed
//  internally. Each bit is presented to the pattern detector with a one-cycle valid strobe.
//  Sits between the stream ROM, the tick generator and the pattern detector / display path.
//  Supports single-pass and looping runs, and can be aborted at any time.
// PARAMETERS
//  ADDR_W  4   ROM address width
//  DEPTH   16  number of ROM entries used (2..2**ADDR_W); last address used = DEPTH-1
//  RD_LAT  1   ROM read latency in clocks after the first enabled edge (1..3)
// PORTS
//  clock_100Mhz  in   1       system clock, 100 MHz
//  reset         in   1       asynchronous, active-high
//  start         in   1       pulse; begins a run at address 0 (ignored while busy)
//  halt          in   1       aborts the run; has priority over start
//  step_tick     in   1       one-cycle pacing enable
//  loop_mode     in   1       1: wrap DEPTH-1 -> 0 and continue; 0: stop after DEPTH-1
//  rom_en        out  1       ROM enable
//  rom_addr      out  ADDR_W  ROM address
//  rom_dout      in   1       ROM read data
//  bit_out       out  1       last bit fetched; held until the next fetch
//  bit_valid     out  1       one-cycle strobe; bit_out is new in this cycle
//  busy          out  1       high in every state except IDLE
//  done          out  1       one-cycle pulse at the end of a non-looping run
//  pass_count    out  8       completed passes since start; saturates at 255
// BEHAVIOUR
//  Reset (async): state=IDLE. rom_en, rom_addr, bit_out, bit_valid, busy, done and
//   pass_count are all 0. Internal latency counter is 0.
//  States: IDLE, WAIT_TICK, FETCH, EMIT. rom_en=1 only in FETCH (Moore output).
//  IDLE:
//   - start & !halt -> WAIT_TICK; rom_addr<=0; pass_count<=0.
//  WAIT_TICK:
//   - step_tick -> FETCH; lat_cnt<=RD_LAT. rom_addr is held stable from here on.
//  FETCH, each edge:
//   - lat_cnt!=0 -> lat_cnt--.
//   - lat_cnt==0 -> EMIT; bit_out<=rom_dout; bit_valid<=1.
//  EMIT (exactly 1 cycle, bit_valid=1):
//   - rom_addr!=DEPTH-1 -> rom_addr<=rom_addr+1; go to WAIT_TICK.
//   - rom_addr==DEPTH-1 -> pass_count<=sat(pass_count+1), then:
//       loop_mode=1 -> rom_addr<=0; go to WAIT_TICK.
//       loop_mode=0 -> done<=1 for 1 cycle; go to IDLE; rom_addr<=0.
//   - loop_mode is sampled only in EMIT.
//  Timing: tick sampled at edge E0 -> bit_valid high during the cycle after edge
//   E0+RD_LAT+1. Minimum bit period is RD_LAT+3 clocks.
//  step_tick outside WAIT_TICK is ignored, not queued. start while busy is ignored.
//  halt (any state except IDLE): next edge -> IDLE; rom_addr<=0; bit_valid=0; done=0.
//   bit_out and pass_count are held.
//  halt and start in the same cycle in IDLE: stay in IDLE.
//  halt in the EMIT cycle: the strobe already issued stands; no done, no pass increment.
//  Reset mid-run: immediate return to the reset values; no done pulse.
//  rom_addr arithmetic is modulo 2**ADDR_W, but it never exceeds DEPTH-1.
// TESTING
//  1. DEPTH=16, RD_LAT=1, ROM bits 0xA5F0 (addr0 = LSB), loop_mode=0, tick every 10 clk
//     -> 16 bit_valid strobes with bits 0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1; each strobe
//     3 clk after its tick; done once; pass_count=1; busy=0 afterwards.
//  2. loop_mode=1, same ROM, 48 ticks -> 48 strobes; rom_addr wraps 15->0 three times;
//     pass_count=3; done never asserts.
//  3. step_tick held high continuously, RD_LAT=1 -> one strobe every 4 clk; ticks seen
//     in FETCH/EMIT produce no extra strobes. With RD_LAT=3 -> one strobe every 6 clk.
//  4. halt while rom_addr=7 -> IDLE at the next edge; rom_addr=0; no done; pass_count held.
//     start+halt together in IDLE -> busy stays 0.
//  5. reset pulsed during FETCH -> all outputs 0 immediately. After release and a start,
//     the first strobe carries the addr-0 bit.
//  6. DEPTH=4, loop_mode=1, 1300 ticks -> pass_count increments to 255 and stays at 255.

Source files
------------

// File: rtl/rom_bit_sequencer.sv
// Steps through a 1-bit block ROM one address per pacing tick,
// absorbing ROM read latency and strobing each bit to the detector.
//
// Ports:
//   clock_100Mhz, reset  clock, async active-high reset
//   start, halt          begin run at addr 0 / abort (halt wins)
//   step_tick            one-cycle pacing enable
//   loop_mode            1: wrap and keep going, 0: single pass
//   rom_en, rom_addr     ROM request, rom_dout is its read data
//   bit_out, bit_valid   fetched bit and its one-cycle strobe
//   busy, done           run active / end-of-single-pass pulse
//   pass_count           completed passes, saturating at 255
module rom_bit_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              step_tick,
  input  logic              loop_mode,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_dout,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pass_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    FETCH,
    EMIT
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t     state;
  logic [1:0] lat_cnt;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_count <= '0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      if (halt && state != IDLE) begin
        // Abort: bit_out and pass_count keep their values.
        state    <= IDLE;
        rom_addr <= '0;
        rom_en   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !halt) begin
              state      <= WAIT_TICK;
              rom_addr   <= '0;
              pass_count <= '0;
              busy       <= 1'b1;
            end
          end
          WAIT_TICK: begin
            if (step_tick) begin
              state   <= FETCH;
              lat_cnt <= LAT_INIT;
              rom_en  <= 1'b1;
            end
          end
          FETCH: begin
            // One extra edge beyond RD_LAT so the ROM
            // output is sampled after it has settled.
            if (lat_cnt != 2'd0) begin
              lat_cnt <= lat_cnt - 2'd1;
            end else begin
              state     <= EMIT;
              bit_out   <= rom_dout;
              bit_valid <= 1'b1;
              rom_en    <= 1'b0;
            end
          end
          EMIT: begin
            if (rom_addr != LAST) begin
              rom_addr <= rom_addr + 1'b1;
              state    <= WAIT_TICK;
            end else begin
              if (pass_count != 8'hFF)
                pass_count <= pass_count + 8'd1;
              rom_addr <= '0;
              if (loop_mode) begin
                state <= WAIT_TICK;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
